// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 instruction-sequencing controller.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP,
        S_JSR, S_JSR_PC, S_JSR_R,
        S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3,
        S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BUS  = 2'b01;
    localparam logic [1:0] PC_ADDR = 2'b10;

    localparam logic [1:0] A2_ZERO  = 2'b00;
    localparam logic [1:0] A2_OFF6  = 2'b01;
    localparam logic [1:0] A2_OFF9  = 2'b10;
    localparam logic [1:0] A2_OFF11 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b10;
    localparam logic [1:0] ALU_PASSA = 2'b11;

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Control bundle between the LC-3 sequencer (master) and the datapath (slave).
interface lc3_control_fsm_if;

    logic       Run, Continue;
    logic [3:0] Opcode;
    logic       IR_5, IR_11, BEN;
    logic       LD_MAR, LD_MDR, LD_IR, LD_PC, LD_BEN, LD_CC, LD_REG;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       ADDR1MUX, SR1MUX, SR2MUX, DRMUX;
    logic       MIO_EN, Mem_OE, Mem_WE, Paused;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_PC, LD_BEN, LD_CC, LD_REG,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, ADDR2MUX, ALUK, ADDR1MUX, SR1MUX, SR2MUX, DRMUX,
               MIO_EN, Mem_OE, Mem_WE, Paused
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_PC, LD_BEN, LD_CC, LD_REG,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, ADDR2MUX, ALUK, ADDR1MUX, SR1MUX, SR2MUX, DRMUX,
               MIO_EN, Mem_OE, Mem_WE, Paused
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Memory wait-state counter: runs 0..MEM_WAIT-1 while enabled, self-clears on done.
module mem_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic done
);

    logic [2:0] count;

    assign done = en && (count == 3'(MEM_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 3'd0;
        else if (en && !done)
            count <= count + 3'd1;
        else
            count <= 3'd0;
    end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 ISDU: Moore sequencer driving datapath loads, gates, muxes and memory strobes.
module lc3_control_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    lc3_control_fsm_if.master bus
);

    state_t state, state_next;
    logic   wait_en, wait_done;

    assign wait_en = (state == S_FETCH2) || (state == S_LDR2) || (state == S_STR3);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk   (Clk),
        .rst_n (Reset),
        .en    (wait_en),
        .done  (wait_done)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= S_HALTED;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = PC_INC;
        bus.ADDR2MUX   = A2_ZERO;
        bus.ADDR1MUX   = 1'b0;
        bus.ALUK       = ALU_ADD;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.DRMUX      = 1'b0;
        bus.MIO_EN     = 1'b0;
        bus.Mem_OE     = 1'b0;
        bus.Mem_WE     = 1'b0;
        bus.Paused     = 1'b0;

        case (state)
            S_HALTED: if (bus.Run) state_next = S_FETCH1;
            S_FETCH1: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                state_next = S_FETCH2;
            end
            S_FETCH2, S_LDR2: begin
                bus.Mem_OE = 1'b1;
                bus.MIO_EN = 1'b1;
                if (wait_done) begin
                    bus.LD_MDR = 1'b1;
                    state_next = (state == S_FETCH2) ? S_FETCH3 : S_LDR3;
                end
            end
            S_FETCH3: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                state_next  = S_DECODE;
            end
            S_DECODE: begin
                bus.LD_BEN = 1'b1;
                case (bus.Opcode)
                    OP_ADD:  state_next = S_ADD;
                    OP_AND:  state_next = S_AND;
                    OP_NOT:  state_next = S_NOT;
                    OP_BR:   state_next = S_BR;
                    OP_JMP:  state_next = S_JMP;
                    OP_JSR:  state_next = S_JSR;
                    OP_LDR:  state_next = S_LDR1;
                    OP_STR:  state_next = S_STR1;
                    OP_PSE:  state_next = S_PAUSE1;
                    default: state_next = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                bus.SR1MUX  = 1'b1;
                bus.SR2MUX  = (state == S_NOT) ? 1'b0 : bus.IR_5;
                bus.ALUK    = (state == S_ADD) ? ALU_ADD : (state == S_AND) ? ALU_AND : ALU_NOT;
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                state_next  = S_FETCH1;
            end
            S_BR: state_next = bus.BEN ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN: begin
                bus.ADDR2MUX = A2_OFF9;
                bus.PCMUX    = PC_ADDR;
                bus.LD_PC    = 1'b1;
                state_next   = S_FETCH1;
            end
            S_JMP: begin
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = ALU_PASSA;
                bus.GateALU = 1'b1;
                bus.PCMUX   = PC_BUS;
                bus.LD_PC   = 1'b1;
                state_next  = S_FETCH1;
            end
            // R7 captures the already-incremented PC before the jump target is loaded
            S_JSR: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
                state_next = bus.IR_11 ? S_JSR_PC : S_JSR_R;
            end
            S_JSR_PC: begin
                bus.ADDR2MUX = A2_OFF11;
                bus.PCMUX    = PC_ADDR;
                bus.LD_PC    = 1'b1;
                state_next   = S_FETCH1;
            end
            S_JSR_R: begin
                bus.SR1MUX   = 1'b1;
                bus.ADDR1MUX = 1'b1;
                bus.PCMUX    = PC_ADDR;
                bus.LD_PC    = 1'b1;
                state_next   = S_FETCH1;
            end
            S_LDR1, S_STR1: begin
                bus.SR1MUX     = 1'b1;
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = A2_OFF6;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                state_next     = (state == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR3: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                state_next  = S_FETCH1;
            end
            S_STR2: begin
                bus.ALUK    = ALU_PASSA;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                state_next  = S_STR3;
            end
            S_STR3: begin
                bus.Mem_WE = 1'b1;
                if (wait_done) state_next = S_FETCH1;
            end
            // Two pause states make a held Continue resume exactly once
            S_PAUSE1: begin
                bus.Paused = 1'b1;
                if (bus.Continue) state_next = S_PAUSE2;
            end
            S_PAUSE2: begin
                bus.Paused = 1'b1;
                if (!bus.Continue) state_next = S_FETCH1;
            end
            default: state_next = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed-vector bench for lc3_control_fsm; two instances with MEM_WAIT=2 and MEM_WAIT=3.
module tb_lc3_control_fsm;

    logic Clk = 1'b0;
    logic Reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 Clk = ~Clk;

    lc3_control_fsm_if if_a ();
    lc3_control_fsm_if if_b ();

    lc3_control_fsm #(.MEM_WAIT(2)) dut_a (.Clk(Clk), .Reset(Reset), .bus(if_a.master));
    lc3_control_fsm #(.MEM_WAIT(3)) dut_b (.Clk(Clk), .Reset(Reset), .bus(if_b.master));

    assign if_b.Run      = if_a.Run;
    assign if_b.Continue = if_a.Continue;
    assign if_b.Opcode   = if_a.Opcode;
    assign if_b.IR_5     = if_a.IR_5;
    assign if_b.IR_11    = if_a.IR_11;
    assign if_b.BEN      = if_a.BEN;

    logic [24:0] ow_a, ow_b;
    assign ow_a = {if_a.LD_MAR, if_a.LD_MDR, if_a.LD_IR, if_a.LD_PC, if_a.LD_BEN, if_a.LD_CC, if_a.LD_REG,
                   if_a.GatePC, if_a.GateMDR, if_a.GateALU, if_a.GateMARMUX,
                   if_a.PCMUX, if_a.ADDR2MUX, if_a.ADDR1MUX, if_a.ALUK,
                   if_a.SR1MUX, if_a.SR2MUX, if_a.DRMUX, if_a.MIO_EN, if_a.Mem_OE, if_a.Mem_WE, if_a.Paused};
    assign ow_b = {if_b.LD_MAR, if_b.LD_MDR, if_b.LD_IR, if_b.LD_PC, if_b.LD_BEN, if_b.LD_CC, if_b.LD_REG,
                   if_b.GatePC, if_b.GateMDR, if_b.GateALU, if_b.GateMARMUX,
                   if_b.PCMUX, if_b.ADDR2MUX, if_b.ADDR1MUX, if_b.ALUK,
                   if_b.SR1MUX, if_b.SR2MUX, if_b.DRMUX, if_b.MIO_EN, if_b.Mem_OE, if_b.Mem_WE, if_b.Paused};

    localparam logic [24:0] B_LD_MAR  = 25'(1) << 24;
    localparam logic [24:0] B_LD_MDR  = 25'(1) << 23;
    localparam logic [24:0] B_LD_IR   = 25'(1) << 22;
    localparam logic [24:0] B_LD_PC   = 25'(1) << 21;
    localparam logic [24:0] B_LD_BEN  = 25'(1) << 20;
    localparam logic [24:0] B_LD_CC   = 25'(1) << 19;
    localparam logic [24:0] B_LD_REG  = 25'(1) << 18;
    localparam logic [24:0] B_G_PC    = 25'(1) << 17;
    localparam logic [24:0] B_G_MDR   = 25'(1) << 16;
    localparam logic [24:0] B_G_ALU   = 25'(1) << 15;
    localparam logic [24:0] B_G_MARMX = 25'(1) << 14;
    localparam logic [24:0] F_PC_BUS  = 25'(1) << 12;
    localparam logic [24:0] F_PC_ADR  = 25'(2) << 12;
    localparam logic [24:0] F_A2_OFF6 = 25'(1) << 10;
    localparam logic [24:0] F_A2_OFF9 = 25'(2) << 10;
    localparam logic [24:0] F_A2_O11  = 25'(3) << 10;
    localparam logic [24:0] B_ADDR1   = 25'(1) << 9;
    localparam logic [24:0] F_ALU_AND = 25'(1) << 7;
    localparam logic [24:0] F_ALU_NOT = 25'(2) << 7;
    localparam logic [24:0] F_ALU_PA  = 25'(3) << 7;
    localparam logic [24:0] B_SR1     = 25'(1) << 6;
    localparam logic [24:0] B_SR2     = 25'(1) << 5;
    localparam logic [24:0] B_DR      = 25'(1) << 4;
    localparam logic [24:0] B_MIO     = 25'(1) << 3;
    localparam logic [24:0] B_OE      = 25'(1) << 2;
    localparam logic [24:0] B_WE      = 25'(1) << 1;
    localparam logic [24:0] B_PAUSED  = 25'(1) << 0;

    localparam logic [24:0] E_IDLE  = 25'd0;
    localparam logic [24:0] E_F1    = B_G_PC | B_LD_MAR | B_LD_PC;
    localparam logic [24:0] E_RDW   = B_MIO | B_OE;
    localparam logic [24:0] E_RDL   = B_MIO | B_OE | B_LD_MDR;
    localparam logic [24:0] E_F3    = B_G_MDR | B_LD_IR;
    localparam logic [24:0] E_DEC   = B_LD_BEN;
    localparam logic [24:0] E_ADDI  = B_SR1 | B_SR2 | B_G_ALU | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_ANDR  = B_SR1 | F_ALU_AND | B_G_ALU | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_NOT   = B_SR1 | F_ALU_NOT | B_G_ALU | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_BRT   = F_A2_OFF9 | F_PC_ADR | B_LD_PC;
    localparam logic [24:0] E_JMP   = B_SR1 | F_ALU_PA | B_G_ALU | F_PC_BUS | B_LD_PC;
    localparam logic [24:0] E_JSR   = B_G_PC | B_DR | B_LD_REG;
    localparam logic [24:0] E_JSRPC = F_A2_O11 | F_PC_ADR | B_LD_PC;
    localparam logic [24:0] E_JSRR  = B_SR1 | B_ADDR1 | F_PC_ADR | B_LD_PC;
    localparam logic [24:0] E_MADR  = B_SR1 | B_ADDR1 | F_A2_OFF6 | B_G_MARMX | B_LD_MAR;
    localparam logic [24:0] E_LDR3  = B_G_MDR | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_STR2  = F_ALU_PA | B_G_ALU | B_LD_MDR;
    localparam logic [24:0] E_WR    = B_WE;
    localparam logic [24:0] E_PAUSE = B_PAUSED;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Checks the current negedge against exp[0], then one cycle per further entry.
    task automatic expect_seq(input string name, input bit sel_b, input logic [24:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i != 0) tick();
            chk($sformatf("%s[%0d]", name, i), sel_b ? 32'(ow_b) : 32'(ow_a), 32'(exp[i]));
        end
    endtask

    task automatic pulse_run();
        if_a.Run = 1'b1;
        tick();
        if_a.Run = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        chk("halted_a", 32'(ow_a), 32'(E_IDLE));
        chk("halted_b", 32'(ow_b), 32'(E_IDLE));
    endtask

    logic [24:0] str_a[$];
    logic [24:0] str_b[$];

    initial begin
        Reset         = 1'b0;
        if_a.Run      = 1'b0;
        if_a.Continue = 1'b0;
        if_a.Opcode   = 4'b0001;
        if_a.IR_5     = 1'b1;
        if_a.IR_11    = 1'b0;
        if_a.BEN      = 1'b0;
        tick();
        chk("reset_a", 32'(ow_a), 32'(E_IDLE));
        chk("reset_b", 32'(ow_b), 32'(E_IDLE));
        Reset = 1'b1;
        tick();
        tick();
        chk("halt_no_run", 32'(ow_a), 32'(E_IDLE));

        // ADD immediate: FETCH1 again on the 7th cycle after Run
        pulse_run();
        expect_seq("add", 1'b0, '{E_F1, E_RDW, E_RDL, E_F3, E_DEC, E_ADDI, E_F1});

        do_reset();
        if_a.Opcode = 4'b0000;
        if_a.BEN    = 1'b1;
        pulse_run();
        expect_seq("br_taken", 1'b0, '{E_F1, E_RDW, E_RDL, E_F3, E_DEC, E_IDLE, E_BRT, E_F1});
        if_a.BEN = 1'b0;
        tick();
        expect_seq("br_not", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_IDLE, E_F1});

        // STR on both instances in lockstep
        do_reset();
        if_a.Opcode = 4'b0111;
        str_a = '{E_F1, E_RDW, E_RDL, E_F3, E_DEC, E_MADR, E_STR2, E_WR, E_WR, E_F1, E_RDW, E_RDL};
        str_b = '{E_F1, E_RDW, E_RDW, E_RDL, E_F3, E_DEC, E_MADR, E_STR2, E_WR, E_WR, E_WR, E_F1};
        pulse_run();
        for (int i = 0; i < 12; i++) begin
            if (i != 0) tick();
            chk($sformatf("str_w2[%0d]", i), 32'(ow_a), 32'(str_a[i]));
            chk($sformatf("str_w3[%0d]", i), 32'(ow_b), 32'(str_b[i]));
        end
        tick();
        expect_seq("str_again_w3", 1'b1, '{E_RDW, E_RDW, E_RDL, E_F3, E_DEC, E_MADR, E_STR2, E_WR, E_WR});
        // reset lands between clock edges in the second write cycle
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_b", 32'(ow_b), 32'(E_IDLE));
        chk("async_rst_a", 32'(ow_a), 32'(E_IDLE));
        tick();
        Reset = 1'b1;
        tick();
        chk("post_rst_halt1", 32'(ow_b), 32'(E_IDLE));
        tick();
        chk("post_rst_halt2", 32'(ow_b), 32'(E_IDLE));

        // PSE with Continue held high for 10 cycles
        if_a.Opcode = 4'b1101;
        pulse_run();
        expect_seq("pse", 1'b0, '{E_F1, E_RDW, E_RDL, E_F3, E_DEC, E_PAUSE, E_PAUSE, E_PAUSE});
        if_a.Continue = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("pse_held[%0d]", i), 32'(ow_a), 32'(E_PAUSE));
        end
        if_a.Continue = 1'b0;
        tick();
        chk("pse_resume", 32'(ow_a), 32'(E_F1));

        if_a.Opcode = 4'b1111;
        tick();
        expect_seq("nop", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_F1});

        if_a.Opcode = 4'b0100;
        if_a.IR_11  = 1'b1;
        tick();
        expect_seq("jsr_pc", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_JSR, E_JSRPC, E_F1});
        if_a.IR_11 = 1'b0;
        tick();
        expect_seq("jsr_r", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_JSR, E_JSRR, E_F1});

        if_a.Opcode = 4'b0110;
        tick();
        expect_seq("ldr", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_MADR, E_RDW, E_RDL, E_LDR3, E_F1});

        if_a.Opcode = 4'b1001;
        tick();
        expect_seq("not", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_NOT, E_F1});

        if_a.Opcode = 4'b1100;
        tick();
        expect_seq("jmp", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_JMP, E_F1});

        if_a.Opcode = 4'b0101;
        if_a.IR_5   = 1'b0;
        tick();
        expect_seq("and_reg", 1'b0, '{E_RDW, E_RDL, E_F3, E_DEC, E_ANDR, E_F1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lc3_control_fsm.md
Name: lc3_control_fsm

Overview:
- Instruction-sequencing controller (ISDU) for the LC-3 datapath.
- Drives every load enable, bus gate, mux select and memory strobe of the datapath from the opcode, BEN and the Run/Continue switches.
- Stretches every memory access to a programmable number of wait cycles.
- Implements the PSE pause handshake with the front panel.

Parameters:
MEM_WAIT, 2, cycles Mem_OE/Mem_WE held per access before the data/write is taken (legal range 1..7)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Run  in  1  start execution from HALTED
Continue  in  1  resume from PSE pause
Opcode  in  4  IR[15:12]
IR_5  in  1  immediate/register select for ADD/AND
IR_11  in  1  JSR (1) vs JSRR (0)
BEN  in  1  registered branch-enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_PC, LD_BEN, LD_CC, LD_REG  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle
PCMUX  out  2  00 PC+1, 01 bus, 10 address adder
ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
ADDR1MUX  out  1  0 PC, 1 SR1
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
SR2MUX  out  1  0 register, 1 sext imm5
DRMUX  out  1  0 IR[11:9], 1 R7
MIO_EN  out  1  MDR loads from memory when 1
Mem_OE  out  1  memory read strobe, active high
Mem_WE  out  1  memory write strobe, active high
Paused  out  1  high in both PAUSE states

Behaviour:
Reset and defaults:
- Reset low -> state HALTED, wait counter 0, all outputs 0, asynchronously.
- In every state, outputs not listed below are 0. Outputs are a Moore decode of the registered state only.

Transitions:
- HALTED: Run=1 -> FETCH1. Run is ignored in all other states.
- FETCH1: GatePC, LD_MAR, PCMUX=00, LD_PC -> FETCH2.
- FETCH2 (read wait): Mem_OE, MIO_EN; counter counts 0..MEM_WAIT-1. In the final cycle also LD_MDR, then -> FETCH3. Counter clears on leaving.
- FETCH3: GateMDR, LD_IR -> DECODE.
- DECODE: LD_BEN; next state by Opcode:
  - 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR, 0111 STR, 1101 PSE.
  - Any other opcode -> FETCH1 (NOP). No register, memory or CC changes.
- ADD/AND: SR1MUX=1, SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC -> FETCH1.
- NOT: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC -> FETCH1.
- BR: BEN=1 -> BR_TAKEN, else -> FETCH1.
- BR_TAKEN: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> FETCH1.
- JMP: SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC -> FETCH1.
- JSR: GatePC, DRMUX=1, LD_REG -> JSR_PC if IR_11, else JSR_R. R7 receives the incremented PC.
- JSR_PC: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC -> FETCH1.
- JSR_R: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> FETCH1.
- LDR1: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> LDR2.
- LDR2: read wait identical to FETCH2 -> LDR3.
- LDR3: GateMDR, DRMUX=0, LD_REG, LD_CC -> FETCH1.
- STR1: as LDR1 -> STR2.
- STR2: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR -> STR3.
- STR3 (write wait): Mem_WE held MEM_WAIT cycles -> FETCH1.
- PAUSE1: Paused; Continue=1 -> PAUSE2.
- PAUSE2: Paused; Continue=0 -> FETCH1. A held Continue therefore resumes exactly once.

Boundary conditions:
- MEM_WAIT=1 gives single-cycle wait states.
- Counter width is 3 bits.
- Reset mid-wait aborts the access with no write completing after Reset falls.
- Gate outputs are mutually exclusive by construction.

Decomposition:
- Package lc3_ctrl_pkg: state enum, opcode localparams, PCMUX/ADDR2MUX/ALUK encodings.
- Sub-module mem_wait_counter: load/clear, done pulse at MEM_WAIT-1, shared by FETCH2, LDR2 and STR3.

Test Plan:
- Reset low, then Run pulse, MEM_WAIT=2, Opcode=0001, IR_5=1 -> FETCH1, FETCH2 x2 (Mem_OE high, LD_MDR on 2nd cycle only), FETCH3, DECODE, ADD with SR2MUX=1, LD_REG=1, LD_CC=1; back in FETCH1 on cycle 7.
- Opcode=0000, BEN=1 -> BR_TAKEN asserts PCMUX=10, ADDR2MUX=10, LD_PC. With BEN=0 -> FETCH1 directly after BR, LD_PC never high.
- Opcode=0111, MEM_WAIT=3 -> LD_MAR in STR1, LD_MDR with MIO_EN=0 in STR2, Mem_WE high exactly 3 cycles, then FETCH1.
- Opcode=1101, Continue held high 10 cycles then low -> Paused high until the cycle after Continue falls; single return to FETCH1.
- Reset driven low during 2nd Mem_WE cycle of STR3 -> all outputs 0 immediately; HALTED until Run.
- Opcode=1111 -> DECODE then FETCH1; no LD_REG, LD_CC, LD_PC or Mem_WE asserted outside fetch.
